// File: rtl/mem_port_arbiter.sv
// Three-port arbiter (fetch, load/store, debug) in front of one single-port memory.
// Two-cycle access: ISSUE presents address/data, RESP returns read data.
module mem_port_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_gnt,
    output logic          x_done,
    output logic [DW-1:0] x_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_data,
    output logic          mem_wren,
    input  logic [DW-1:0] mem_q,
    output logic          busy,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_I    = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;
    localparam logic [1:0] OWN_X    = 2'd3;
    localparam logic [7:0] LIMIT    = 8'(STARVE_LIMIT);

    state_t        state;
    logic [7:0]    starve_cnt;
    logic          cur_we;
    logic [DW-1:0] i_hold, d_hold, x_hold;

    logic          arb_en, in_resp;
    logic          i_elig, d_elig, x_elig;
    logic [1:0]    win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_data;

    assign in_resp = (state == RESP);
    assign arb_en  = (state == IDLE) || in_resp;

    // The owner in RESP is excluded so a req held across done is not re-granted.
    assign i_elig = i_req && !(in_resp && owner == OWN_I);
    assign d_elig = d_req && !(in_resp && owner == OWN_D);
    assign x_elig = x_req && !(in_resp && owner == OWN_X);

    always_comb begin
        win = OWN_NONE;
        if (arb_en) begin
            if (x_elig && starve_cnt >= LIMIT) win = OWN_X;
            else if (d_elig)                   win = OWN_D;
            else if (i_elig)                   win = OWN_I;
            else if (x_elig)                   win = OWN_X;
        end
    end

    always_comb begin
        win_we   = 1'b0;
        win_addr = '0;
        win_data = '0;
        unique case (win)
            OWN_I: win_addr = i_addr;
            OWN_D: begin
                win_we   = d_we;
                win_addr = d_addr;
                win_data = d_wdata;
            end
            OWN_X: begin
                win_we   = x_we;
                win_addr = x_addr;
                win_data = x_wdata;
            end
            default: ;
        endcase
    end

    // Read data flows straight from mem_q during RESP, then is held.
    assign i_rdata = (in_resp && owner == OWN_I && !cur_we) ? mem_q : i_hold;
    assign d_rdata = (in_resp && owner == OWN_D && !cur_we) ? mem_q : d_hold;
    assign x_rdata = (in_resp && owner == OWN_X && !cur_we) ? mem_q : x_hold;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            busy        <= 1'b0;
            cur_we      <= 1'b0;
            starve_cnt  <= '0;
            i_gnt       <= 1'b0;
            d_gnt       <= 1'b0;
            x_gnt       <= 1'b0;
            i_done      <= 1'b0;
            d_done      <= 1'b0;
            x_done      <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            i_hold      <= '0;
            d_hold      <= '0;
            x_hold      <= '0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            x_gnt    <= 1'b0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            x_done   <= 1'b0;
            mem_wren <= 1'b0;

            if (in_resp && !cur_we) begin
                unique case (owner)
                    OWN_I:   i_hold <= mem_q;
                    OWN_D:   d_hold <= mem_q;
                    OWN_X:   x_hold <= mem_q;
                    default: ;
                endcase
            end

            if (state == ISSUE) begin
                state  <= RESP;
                i_done <= (owner == OWN_I);
                d_done <= (owner == OWN_D);
                x_done <= (owner == OWN_X);
            end else if (win != OWN_NONE) begin
                state       <= ISSUE;
                owner       <= win;
                busy        <= 1'b1;
                cur_we      <= win_we;
                mem_address <= win_addr;
                mem_data    <= win_data;
                mem_wren    <= win_we;
                i_gnt       <= (win == OWN_I);
                d_gnt       <= (win == OWN_D);
                x_gnt       <= (win == OWN_X);
            end else begin
                state <= IDLE;
                owner <= OWN_NONE;
                busy  <= 1'b0;
            end

            if (arb_en) begin
                if (!x_req || win == OWN_X)
                    starve_cnt <= '0;
                else if (win != OWN_NONE && starve_cnt != 8'hFF)
                    starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

endmodule
